// File: rtl/alu_cmd_seq.sv
// Byte-stream command sequencer: collects opSel/opA/opB, drives an external ALU, returns its result.
// Optional macro ALU_CMD_SEQ_ILLEGAL_OP_EN rejects opSel bytes above 0x06 with an err pulse.
module alu_cmd_seq #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] alu_opSel,
    output logic [7:0] alu_opA,
    output logic [7:0] alu_opB,
    input  logic [7:0] alu_out,
    output logic [7:0] res_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        EXEC,
        SEND
    } state_e;

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_e           state_q, state_d;
    logic [7:0]       op_sel_q, op_sel_d;
    logic [7:0]       op_a_q, op_a_d;
    logic [7:0]       op_b_q, op_b_d;
    logic [7:0]       res_q, res_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic timeout_hit;
    logic illegal_op;

    assign accept      = in_valid && in_ready;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

`ifdef ALU_CMD_SEQ_ILLEGAL_OP_EN
    assign illegal_op = (in_data > 8'h06);
`else
    assign illegal_op = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_sel_q <= 8'h00;
            op_a_q   <= 8'h00;
            op_b_q   <= 8'h00;
            res_q    <= 8'h00;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            op_sel_q <= op_sel_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        op_sel_d = op_sel_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        res_d    = res_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    if (illegal_op) begin
                        err_d = 1'b1;
                    end else begin
                        op_sel_d = in_data;
                        state_d  = GET_A;
                    end
                end
            end
            GET_A, GET_B: begin
                // An accepted byte wins over a timeout landing on the same cycle.
                if (accept) begin
                    cnt_d = '0;
                    if (state_q == GET_A) begin
                        op_a_d  = in_data;
                        state_d = GET_B;
                    end else begin
                        op_b_d  = in_data;
                        state_d = EXEC;
                    end
                end else if (timeout_hit) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (TIMEOUT_CYC != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EXEC: begin
                res_d   = alu_out;
                state_d = SEND;
            end
            SEND: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = !rst && ((state_q == IDLE) || (state_q == GET_A) || (state_q == GET_B));
        busy      = (state_q != IDLE);
        res_valid = (state_q == SEND);
    end

    assign alu_opSel = op_sel_q;
    assign alu_opA   = op_a_q;
    assign alu_opB   = op_b_q;
    assign res_data  = res_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq with a small reference ALU attached and TIMEOUT_CYC=4.
module tb_alu_cmd_seq;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_opSel;
    logic [7:0] alu_opA;
    logic [7:0] alu_opB;
    logic [7:0] alu_out;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ready;
    logic       err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    alu_cmd_seq #(.TIMEOUT_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_opSel (alu_opSel),
        .alu_opA   (alu_opA),
        .alu_opB   (alu_opB),
        .alu_out   (alu_out),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: 0 add, 1 sub, 2 xor, 3 and, 4 or, 5 shl-by-1 of A, 6 nor, others 0.
    always_comb begin
        case (alu_opSel)
            8'h00:   alu_out = alu_opA + alu_opB;
            8'h01:   alu_out = alu_opA - alu_opB;
            8'h02:   alu_out = alu_opA ^ alu_opB;
            8'h03:   alu_out = alu_opA & alu_opB;
            8'h04:   alu_out = alu_opA | alu_opB;
            8'h05:   alu_out = {alu_opA[6:0], 1'b0};
            8'h06:   alu_out = ~(alu_opA | alu_opB);
            default: alu_out = 8'h00;
        endcase
    end

    // Drives one byte and returns #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_byte_ready byte=%02h in_ready=%b required 1", b, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
        send_byte(s);
        send_byte(a);
        send_byte(b);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, res_valid, err, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl in_ready/res_valid/err/busy=%b required 0000",
                     {in_ready, res_valid, err, busy});
        end
        checks++;
        if ({alu_opSel, alu_opA, alu_opB, res_data} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data sel/a/b/res=%08h required 00000000",
                     {alu_opSel, alu_opA, alu_opB, res_data});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_add_latency;
        res_ready = 1'b1;
        send_cmd(8'h00, 8'h05, 8'h03);
        checks++;
        if ({alu_opSel, alu_opA, alu_opB} !== 24'h000503) begin
            errors++;
            $display("FAIL add_operands sel/a/b=%06h required 000503", {alu_opSel, alu_opA, alu_opB});
        end
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL add_exec res_valid=%b in_ready=%b busy=%b required 0 0 1",
                     res_valid, in_ready, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h08) begin
            errors++;
            $display("FAIL add_result res_valid=%b res_data=%02h required 1 08", res_valid, res_data);
        end
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_return res_valid=%b busy=%b in_ready=%b required 0 0 1",
                     res_valid, busy, in_ready);
        end
    endtask

    task automatic test_backpressure;
        res_ready = 1'b0;
        send_cmd(8'h02, 8'h10, 8'h10);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== 8'h00 || in_ready !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d res_valid=%b res_data=%02h in_ready=%b err=%b required 1 00 0 0",
                         i, res_valid, res_data, in_ready, err);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (res_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_still_send res_valid=%b busy=%b required 1 1", res_valid, busy);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_return res_valid=%b busy=%b in_ready=%b required 0 0 1",
                     res_valid, busy, in_ready);
        end
    endtask

    task automatic test_timeout;
        send_byte(8'h01);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (err !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL to_wait cyc=%0d err=%b busy=%b required 0 1", i, err, busy);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL to_fire err=%b busy=%b in_ready=%b required 1 0 1", err, busy, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse_width err=%b required 0", err);
        end
        // Gaps of 3 idle cycles put each next byte on the timeout cycle; the byte must win.
        send_byte(8'h01);
        idle_cycles(3);
        send_byte(8'h09);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_coincide_a err=%b busy=%b required 0 1", err, busy);
        end
        idle_cycles(3);
        send_byte(8'h04);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_coincide_b err=%b busy=%b required 0 1", err, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h05) begin
            errors++;
            $display("FAIL to_result res_valid=%b res_data=%02h required 1 05", res_valid, res_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        send_byte(8'h03);
        send_byte(8'hF0);
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, res_valid, err, busy} !== 4'b0000 ||
            {alu_opSel, alu_opA, alu_opB, res_data} !== 32'h0) begin
            errors++;
            $display("FAIL midrst_state ctrl=%b data=%08h required 0000 00000000",
                     {in_ready, res_valid, err, busy}, {alu_opSel, alu_opA, alu_opB, res_data});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        send_cmd(8'h03, 8'hF0, 8'h3C);
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h30) begin
            errors++;
            $display("FAIL midrst_result res_valid=%b res_data=%02h required 1 30", res_valid, res_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_op;
`ifdef ALU_CMD_SEQ_ILLEGAL_OP_EN
        send_byte(8'h07);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || alu_opSel !== 8'h03) begin
            errors++;
            $display("FAIL ill_reject err=%b busy=%b sel=%02h required 1 0 03", err, busy, alu_opSel);
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ill_after err=%b res_valid=%b busy=%b required 0 0 0", err, res_valid, busy);
        end
        send_cmd(8'h06, 8'h0F, 8'h00);
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'hF0) begin
            errors++;
            $display("FAIL ill_legal res_valid=%b res_data=%02h required 1 F0", res_valid, res_data);
        end
`else
        send_byte(8'h07);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1 || alu_opSel !== 8'h07) begin
            errors++;
            $display("FAIL op7_accept err=%b busy=%b sel=%02h required 0 1 07", err, busy, alu_opSel);
        end
        send_byte(8'h01);
        send_byte(8'h01);
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h00 || err !== 1'b0) begin
            errors++;
            $display("FAIL op7_result res_valid=%b res_data=%02h err=%b required 1 00 0",
                     res_valid, res_data, err);
        end
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        test_reset;
        test_add_latency;
        test_backpressure;
        test_timeout;
        test_reset_mid;
        test_illegal_op;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
